slowlink_frame_rx: RTL and testbench

//  Frame parser directly downstream of the slow-link CDR/8b10b receiver; consumes its decoded word stream.

---
 rtl/slowlink_pkg.sv | 22 ++
 rtl/slowlink_link_monitor.sv | 65 ++++++
 rtl/slowlink_frame_rx.sv | 148 ++++++++++++++
 tb/tb_slowlink_frame_rx.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slowlink_pkg.sv
// Shared types and constants for the slow-link receive path.
package slowlink_pkg;

    typedef enum logic [1:0] {IDLE, LEN, PAYLOAD, CHK} frame_state_t;

    localparam logic [7:0] K28_5        = 8'hBC;
    localparam int         MAX_LEN      = 64;
    localparam int         LOCK_COMMAS  = 4;
    localparam int         ERR_LIMIT    = 3;
    localparam int         TIMEOUT_CLKS = 2000;

    localparam int GC_W  = $clog2(LOCK_COMMAS + 1);
    localparam int EC_W  = $clog2(ERR_LIMIT + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CLKS + 1);
    localparam int REM_W = $clog2(MAX_LEN + 1);

    localparam logic [GC_W-1:0] GC_MAX    = GC_W'(LOCK_COMMAS);
    localparam logic [EC_W-1:0] EC_MAX    = EC_W'(ERR_LIMIT);
    localparam logic [WD_W-1:0] WD_MAX    = WD_W'(TIMEOUT_CLKS);
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

endpackage

// File: rtl/slowlink_link_monitor.sv
// Link lock tracker: good-comma counter, consecutive-error counter, word watchdog.
// link_up_o registered 1 clk after the deciding tick; link_drop_o is the same-cycle falling edge; no backpressure.
module slowlink_link_monitor
    import slowlink_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic word_tick_i,
    input  logic comma_i,
    input  logic error_i,
    output logic link_up_o,
    output logic link_drop_o
);

    logic [GC_W-1:0] gc_q, gc_d;
    logic [EC_W-1:0] ec_q, ec_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            link_up_q, link_up_d;

    always_comb begin
        gc_d      = gc_q;
        ec_d      = ec_q;
        wd_d      = wd_q;
        link_up_d = link_up_q;
        if (word_tick_i) begin
            wd_d = '0;
            if (error_i) begin
                gc_d = '0;
                if (ec_q != EC_MAX) ec_d = ec_q + 1'b1;
                if (ec_d == EC_MAX) link_up_d = 1'b0;
            end else begin
                ec_d = '0;
                if (comma_i) begin
                    if (gc_q != GC_MAX) gc_d = gc_q + 1'b1;
                    if (gc_d == GC_MAX) link_up_d = 1'b1;
                end
            end
        end else begin
            if (wd_q != WD_MAX) wd_d = wd_q + 1'b1;
            // A starved link must re-earn lock from scratch.
            if (wd_d == WD_MAX) begin
                link_up_d = 1'b0;
                gc_d      = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gc_q      <= '0;
            ec_q      <= '0;
            wd_q      <= '0;
            link_up_q <= 1'b0;
        end else begin
            gc_q      <= gc_d;
            ec_q      <= ec_d;
            wd_q      <= wd_d;
            link_up_q <= link_up_d;
        end
    end

    assign link_up_o   = link_up_q;
    assign link_drop_o = link_up_q & ~link_up_d;

endmodule

// File: rtl/slowlink_frame_rx.sv
// Slow-link frame parser: SOF/LEN/payload/CHK extraction, payload byte stream, good/abort flag.
// All outputs registered 1 clk after word_tick_i (watchdog abort needs no tick); no backpressure.
module slowlink_frame_rx
    import slowlink_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        word_tick_i,
    input  logic [7:0]  data_i,
    input  logic        comma_i,
    input  logic        error_i,
    output logic        byte_valid_o,
    output logic [7:0]  byte_o,
    output logic        sof_o,
    output logic        frame_end_o,
    output logic        frame_ok_o,
    output logic        link_up_o,
    output logic [15:0] err_count_o
);

    logic link_up, link_drop;

    slowlink_link_monitor u_link_mon (
        .clk         (clk),
        .reset       (reset),
        .word_tick_i (word_tick_i),
        .comma_i     (comma_i),
        .error_i     (error_i),
        .link_up_o   (link_up),
        .link_drop_o (link_drop)
    );

    frame_state_t     state_q, state_d;
    logic [7:0]       sum_q, sum_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic             first_q, first_d;
    logic             byte_valid_q, byte_valid_d;
    logic [7:0]       byte_q, byte_d;
    logic             sof_q, sof_d;
    logic             frame_end_q, frame_end_d;
    logic             frame_ok_q, frame_ok_d;
    logic [15:0]      err_count_q, err_count_d;

    logic       is_sof, len_ok;
    logic [7:0] chk_sum;

    assign is_sof  = comma_i && (data_i == K28_5) && !error_i;
    assign len_ok  = (data_i != 8'd0) && (data_i <= MAX_LEN_B);
    assign chk_sum = sum_q + data_i;

    always_comb begin
        state_d      = state_q;
        sum_d        = sum_q;
        rem_d        = rem_q;
        first_d      = first_q;
        byte_valid_d = 1'b0;
        byte_d       = byte_q;
        sof_d        = 1'b0;
        frame_end_d  = 1'b0;
        frame_ok_d   = 1'b0;
        err_count_d  = err_count_q;

        if (word_tick_i && error_i && (err_count_q != 16'hFFFF))
            err_count_d = err_count_q + 16'd1;

        if ((state_q != IDLE) && link_drop) begin
            frame_end_d = 1'b1;
            state_d     = IDLE;
        end else if (word_tick_i) begin
            // Errors and commas inside a frame abort it; a clean K28.5 restarts at once.
            if ((state_q != IDLE) && (error_i || comma_i)) begin
                frame_end_d = 1'b1;
                state_d     = is_sof ? LEN : IDLE;
                sum_d       = 8'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (link_up && is_sof) begin
                            state_d = LEN;
                            sum_d   = 8'd0;
                        end
                    end
                    LEN: begin
                        if (len_ok) begin
                            rem_d   = REM_W'(data_i);
                            sum_d   = sum_q + data_i;
                            first_d = 1'b1;
                            state_d = PAYLOAD;
                        end else begin
                            frame_end_d = 1'b1;
                            state_d     = IDLE;
                        end
                    end
                    PAYLOAD: begin
                        byte_valid_d = 1'b1;
                        byte_d       = data_i;
                        sof_d        = first_q;
                        first_d      = 1'b0;
                        sum_d        = sum_q + data_i;
                        rem_d        = rem_q - 1'b1;
                        if (rem_q == REM_W'(1)) state_d = CHK;
                    end
                    CHK: begin
                        frame_end_d = 1'b1;
                        frame_ok_d  = (chk_sum == 8'h00);
                        state_d     = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sum_q        <= 8'd0;
            rem_q        <= '0;
            first_q      <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_q       <= 8'd0;
            sof_q        <= 1'b0;
            frame_end_q  <= 1'b0;
            frame_ok_q   <= 1'b0;
            err_count_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            sum_q        <= sum_d;
            rem_q        <= rem_d;
            first_q      <= first_d;
            byte_valid_q <= byte_valid_d;
            byte_q       <= byte_d;
            sof_q        <= sof_d;
            frame_end_q  <= frame_end_d;
            frame_ok_q   <= frame_ok_d;
            err_count_q  <= err_count_d;
        end
    end

    assign byte_valid_o = byte_valid_q;
    assign byte_o       = byte_q;
    assign sof_o        = sof_q;
    assign frame_end_o  = frame_end_q;
    assign frame_ok_o   = frame_ok_q;
    assign link_up_o    = link_up;
    assign err_count_o  = err_count_q;

endmodule

// File: tb/tb_slowlink_frame_rx.sv
// Scenario bench for slowlink_frame_rx with a word-level reference model.
// Events are encoded as ints: payload byte b -> b (+256 when sof_o), frame end -> 1000 (bad) / 1001 (good).
module tb_slowlink_frame_rx;

    localparam int         LOCK_COMMAS  = 4;
    localparam int         ERR_LIMIT    = 3;
    localparam int         TIMEOUT_CLKS = 2000;
    localparam int         MAX_LEN      = 64;
    localparam logic [7:0] SOF          = 8'hBC;

    logic        clk = 1'b0;
    logic        reset;
    logic        word_tick_i;
    logic [7:0]  data_i;
    logic        comma_i;
    logic        error_i;
    logic        byte_valid_o;
    logic [7:0]  byte_o;
    logic        sof_o;
    logic        frame_end_o;
    logic        frame_ok_o;
    logic        link_up_o;
    logic [15:0] err_count_o;

    int n_vec, n_err, overlap;
    int exp_ev[$];
    int obs_ev[$];

    // Reference model state
    int m_good, m_bad, m_idle, m_len, m_errcnt;
    bit m_link, m_in, m_have_len;
    int m_bytes[$];

    slowlink_frame_rx dut (
        .clk          (clk),
        .reset        (reset),
        .word_tick_i  (word_tick_i),
        .data_i       (data_i),
        .comma_i      (comma_i),
        .error_i      (error_i),
        .byte_valid_o (byte_valid_o),
        .byte_o       (byte_o),
        .sof_o        (sof_o),
        .frame_end_o  (frame_end_o),
        .frame_ok_o   (frame_ok_o),
        .link_up_o    (link_up_o),
        .err_count_o  (err_count_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (byte_valid_o) obs_ev.push_back(int'(byte_o) + (sof_o ? 256 : 0));
            if (frame_end_o)  obs_ev.push_back(frame_ok_o ? 1001 : 1000);
            if (byte_valid_o && frame_end_o) overlap++;
            if (sof_o && !byte_valid_o) overlap++;
        end
    end

    task automatic start_frame();
        m_in = 1'b1; m_have_len = 1'b0; m_bytes.delete();
    endtask

    task automatic model(input bit t, input logic [7:0] d, input bit c, input bit e);
        bit prev_link, sof_word;
        int s;
        prev_link = m_link;
        if (t) begin
            m_idle = 0;
            if (e) begin
                if (m_errcnt < 65535) m_errcnt++;
                m_good = 0;
                m_bad++;
                if (m_bad >= ERR_LIMIT) m_link = 1'b0;
            end else begin
                m_bad = 0;
                if (c) begin
                    m_good++;
                    if (m_good >= LOCK_COMMAS) m_link = 1'b1;
                end
            end
        end else begin
            m_idle++;
            if (m_idle >= TIMEOUT_CLKS) begin m_link = 1'b0; m_good = 0; end
        end

        sof_word = t && c && !e && (d == SOF);
        if (m_in && prev_link && !m_link) begin
            exp_ev.push_back(1000); m_in = 1'b0;
        end else if (t) begin
            if (!m_in) begin
                if (prev_link && sof_word) start_frame();
            end else if (e || c) begin
                exp_ev.push_back(1000); m_in = 1'b0;
                if (sof_word) start_frame();
            end else if (!m_have_len) begin
                if (d == 8'd0 || int'(d) > MAX_LEN) begin
                    exp_ev.push_back(1000); m_in = 1'b0;
                end else begin
                    m_len = int'(d); m_have_len = 1'b1;
                end
            end else if (m_bytes.size() < m_len) begin
                exp_ev.push_back(m_bytes.size() == 0 ? 256 + int'(d) : int'(d));
                m_bytes.push_back(int'(d));
            end else begin
                s = m_len + int'(d);
                foreach (m_bytes[i]) s += m_bytes[i];
                exp_ev.push_back((s % 256) == 0 ? 1001 : 1000);
                m_in = 1'b0;
            end
        end
    endtask

    task automatic cyc(input bit t, input logic [7:0] d, input bit c, input bit e);
        word_tick_i = t; data_i = d; comma_i = c; error_i = e;
        model(t, d, c, e);
        @(posedge clk);
        #1;
        word_tick_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic send(input logic [7:0] d, input bit c, input bit e);
        cyc(1'b1, d, c, e);
        idle($urandom_range(0, 2));
    endtask

    task automatic lock();
        repeat (LOCK_COMMAS) send(SOF, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1; word_tick_i = 1'b0; data_i = 8'h00; comma_i = 1'b0; error_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_good = 0; m_bad = 0; m_idle = 0; m_len = 0; m_errcnt = 0;
        m_link = 1'b0; m_in = 1'b0; m_have_len = 1'b0;
        m_bytes.delete(); exp_ev.delete(); obs_ev.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({byte_valid_o, sof_o, frame_end_o, frame_ok_o, link_up_o} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags: got %b required 00000", {byte_valid_o, sof_o, frame_end_o, frame_ok_o, link_up_o});
        end
        n_vec++;
        if (byte_o !== 8'h00) begin n_err++; $display("FAIL reset_byte: got %h required 00", byte_o); end
        n_vec++;
        if (err_count_o !== 16'h0000) begin n_err++; $display("FAIL reset_err_count: got %h required 0000", err_count_o); end
    endtask

    task automatic test_lock();
        repeat (LOCK_COMMAS - 1) send(SOF, 1'b1, 1'b0);
        n_vec++;
        if (link_up_o !== 1'b0) begin n_err++; $display("FAIL lock_3commas: got %b required 0", link_up_o); end
        send(8'h5A, 1'b0, 1'b0);
        n_vec++;
        if (link_up_o !== 1'b0) begin n_err++; $display("FAIL lock_data_word: got %b required 0", link_up_o); end
        cyc(1'b1, SOF, 1'b1, 1'b0);
        n_vec++;
        if (link_up_o !== 1'b1) begin n_err++; $display("FAIL lock_4th_comma: got %b required 1", link_up_o); end
        idle(2);
        n_vec++;
        if (obs_ev.size() != exp_ev.size()) begin n_err++; $display("FAIL lock event_count: got %0d required %0d", obs_ev.size(), exp_ev.size()); end
        obs_ev.delete(); exp_ev.delete();
    endtask

    task automatic test_good_frame();
        logic [7:0] w [6];
        w = '{SOF, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        foreach (w[i]) send(w[i], i == 0, 1'b0);
        idle(2);
        n_vec++;
        if (obs_ev.size() != 4 || obs_ev[0] != 256 + 'h11 || obs_ev[3] != 1001) begin
            n_err++; $display("FAIL good_frame_shape: got %0d events required 4 ending in good frame", obs_ev.size());
        end
        n_vec++;
        if (obs_ev.size() != exp_ev.size()) begin n_err++; $display("FAIL good_frame event_count: got %0d required %0d", obs_ev.size(), exp_ev.size()); end
        else foreach (exp_ev[i]) begin
            n_vec++;
            if (obs_ev[i] !== exp_ev[i]) begin n_err++; $display("FAIL good_frame event[%0d]: got %0d required %0d", i, obs_ev[i], exp_ev[i]); end
        end
        obs_ev.delete(); exp_ev.delete();
    endtask

    task automatic test_bad_checksum();
        logic [7:0] w [6];
        w = '{SOF, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98};
        foreach (w[i]) send(w[i], i == 0, 1'b0);
        idle(2);
        n_vec++;
        if (obs_ev.size() != 4 || obs_ev[3] != 1000) begin
            n_err++; $display("FAIL bad_chk_shape: got %0d events required 4 ending in bad frame", obs_ev.size());
        end
        n_vec++;
        if (obs_ev.size() != exp_ev.size()) begin n_err++; $display("FAIL bad_chk event_count: got %0d required %0d", obs_ev.size(), exp_ev.size()); end
        else foreach (exp_ev[i]) begin
            n_vec++;
            if (obs_ev[i] !== exp_ev[i]) begin n_err++; $display("FAIL bad_chk event[%0d]: got %0d required %0d", i, obs_ev[i], exp_ev[i]); end
        end
        n_vec++;
        if (err_count_o !== m_errcnt[15:0]) begin n_err++; $display("FAIL bad_chk err_count: got %0d required %0d", err_count_o, m_errcnt); end
        obs_ev.delete(); exp_ev.delete();
    endtask

    task automatic test_error_payload();
        send(SOF, 1'b1, 1'b0); send(8'h04, 1'b0, 1'b0); send(8'hA1, 1'b0, 1'b0);
        send(8'hA2, 1'b0, 1'b1);
        n_vec++;
        if (err_count_o !== m_errcnt[15:0]) begin n_err++; $display("FAIL err_payload err_count: got %0d required %0d", err_count_o, m_errcnt); end
        send(SOF, 1'b1, 1'b0); send(8'h02, 1'b0, 1'b0); send(8'h40, 1'b0, 1'b0);
        send(8'h50, 1'b0, 1'b0); send(8'h6E, 1'b0, 1'b0);
        idle(2);
        n_vec++;
        if (obs_ev.size() != exp_ev.size()) begin n_err++; $display("FAIL err_payload event_count: got %0d required %0d", obs_ev.size(), exp_ev.size()); end
        else foreach (exp_ev[i]) begin
            n_vec++;
            if (obs_ev[i] !== exp_ev[i]) begin n_err++; $display("FAIL err_payload event[%0d]: got %0d required %0d", i, obs_ev[i], exp_ev[i]); end
        end
        obs_ev.delete(); exp_ev.delete();
        send(8'h00, 1'b0, 1'b1); send(8'h00, 1'b0, 1'b1);
        n_vec++;
        if (link_up_o !== 1'b1) begin n_err++; $display("FAIL err_two_errors link_up: got %b required 1", link_up_o); end
        send(8'h00, 1'b0, 1'b1);
        n_vec++;
        if (link_up_o !== 1'b0) begin n_err++; $display("FAIL err_three_errors link_up: got %b required 0", link_up_o); end
        n_vec++;
        if (err_count_o !== m_errcnt[15:0]) begin n_err++; $display("FAIL err_burst err_count: got %0d required %0d", err_count_o, m_errcnt); end
        lock();
        n_vec++;
        if (link_up_o !== 1'b1) begin n_err++; $display("FAIL err_relock: got %b required 1", link_up_o); end
    endtask

    task automatic test_watchdog();
        lock();
        send(SOF, 1'b1, 1'b0); send(8'h05, 1'b0, 1'b0); send(8'h10, 1'b0, 1'b0);
        send(8'h20, 1'b0, 1'b0); cyc(1'b1, 8'h30, 1'b0, 1'b0);
        for (int i = 0; i < TIMEOUT_CLKS + 5; i++) begin
            idle(1);
            n_vec++;
            if (link_up_o !== m_link) begin n_err++; $display("FAIL watchdog link_up at idle %0d: got %b required %b", i, link_up_o, m_link); end
        end
        n_vec++;
        if (link_up_o !== 1'b0) begin n_err++; $display("FAIL watchdog_drop: got %b required 0", link_up_o); end
        n_vec++;
        if (obs_ev.size() != exp_ev.size()) begin n_err++; $display("FAIL watchdog event_count: got %0d required %0d", obs_ev.size(), exp_ev.size()); end
        else foreach (exp_ev[i]) begin
            n_vec++;
            if (obs_ev[i] !== exp_ev[i]) begin n_err++; $display("FAIL watchdog event[%0d]: got %0d required %0d", i, obs_ev[i], exp_ev[i]); end
        end
        obs_ev.delete(); exp_ev.delete();
        repeat (LOCK_COMMAS - 1) send(SOF, 1'b1, 1'b0);
        n_vec++;
        if (link_up_o !== 1'b0) begin n_err++; $display("FAIL watchdog_relock_3: got %b required 0", link_up_o); end
        cyc(1'b1, SOF, 1'b1, 1'b0);
        n_vec++;
        if (link_up_o !== 1'b1) begin n_err++; $display("FAIL watchdog_relock_4: got %b required 1", link_up_o); end
    endtask

    task automatic test_restart_len();
        int s;
        logic [7:0] b;
        send(SOF, 1'b1, 1'b0); send(8'h03, 1'b0, 1'b0); send(8'hAA, 1'b0, 1'b0);
        send(SOF, 1'b1, 1'b0); send(8'h02, 1'b0, 1'b0); send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0); send(8'hCB, 1'b0, 1'b0);
        send(SOF, 1'b1, 1'b0); send(8'h00, 1'b0, 1'b0);
        send(SOF, 1'b1, 1'b0); send(8'h41, 1'b0, 1'b0);
        send(SOF, 1'b1, 1'b0); send(8'h40, 1'b0, 1'b0);
        s = 'h40;
        for (int i = 0; i < MAX_LEN; i++) begin
            b = 8'($urandom);
            s += int'(b);
            send(b, 1'b0, 1'b0);
        end
        send(8'((256 - (s % 256)) % 256), 1'b0, 1'b0);
        idle(2);
        n_vec++;
        if (obs_ev.size() != 72) begin n_err++; $display("FAIL restart_len_shape: got %0d events required 72", obs_ev.size()); end
        n_vec++;
        if (obs_ev.size() != exp_ev.size()) begin n_err++; $display("FAIL restart_len event_count: got %0d required %0d", obs_ev.size(), exp_ev.size()); end
        else foreach (exp_ev[i]) begin
            n_vec++;
            if (obs_ev[i] !== exp_ev[i]) begin n_err++; $display("FAIL restart_len event[%0d]: got %0d required %0d", i, obs_ev[i], exp_ev[i]); end
        end
        obs_ev.delete(); exp_ev.delete();
    endtask

    task automatic test_reset_midframe();
        send(SOF, 1'b1, 1'b0); send(8'h05, 1'b0, 1'b0); send(8'h01, 1'b0, 1'b0);
        cyc(1'b1, 8'h02, 1'b0, 1'b1);
        do_reset();
        idle(3);
        n_vec++;
        if (obs_ev.size() != 0) begin n_err++; $display("FAIL reset_midframe events: got %0d required 0", obs_ev.size()); end
        n_vec++;
        if (link_up_o !== 1'b0 || err_count_o !== 16'h0000) begin
            n_err++; $display("FAIL reset_midframe state: got link %b errs %0d required 0 0", link_up_o, err_count_o);
        end
        obs_ev.delete(); exp_ev.delete();
    endtask

    task automatic test_random();
        int w[$];
        int len, s, b;
        lock();
        for (int f = 0; f < 120; f++) begin
            w.delete();
            if ($urandom_range(0, 7) == 0) w.push_back(int'($urandom_range(0, 255)));
            w.push_back(256 + int'(SOF));
            if ($urandom_range(0, 15) == 0) len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(65, 255));
            else len = int'($urandom_range(1, 8));
            w.push_back(len);
            s = len;
            for (int i = 0; i < len && len <= MAX_LEN; i++) begin
                b = int'($urandom_range(0, 255));
                s += b;
                w.push_back(b);
            end
            w.push_back(($urandom_range(0, 3) != 0) ? (256 - (s % 256)) % 256 : int'($urandom_range(0, 255)));
            for (int i = 1; i < w.size(); i++)
                if ($urandom_range(0, 39) == 0) w[i] = w[i] | (($urandom_range(0, 1) == 0) ? 512 : 256);
            foreach (w[i]) begin
                cyc(1'b1, 8'(w[i]), ((w[i] >> 8) & 1) != 0, ((w[i] >> 9) & 1) != 0);
                n_vec++;
                if (link_up_o !== m_link) begin n_err++; $display("FAIL random link_up frame %0d: got %b required %b", f, link_up_o, m_link); end
                n_vec++;
                if (err_count_o !== m_errcnt[15:0]) begin n_err++; $display("FAIL random err_count frame %0d: got %0d required %0d", f, err_count_o, m_errcnt); end
                idle($urandom_range(0, 1));
            end
        end
        idle(2);
        n_vec++;
        if (obs_ev.size() != exp_ev.size()) begin n_err++; $display("FAIL random event_count: got %0d required %0d", obs_ev.size(), exp_ev.size()); end
        else foreach (exp_ev[i]) begin
            n_vec++;
            if (obs_ev[i] !== exp_ev[i]) begin n_err++; $display("FAIL random event[%0d]: got %0d required %0d", i, obs_ev[i], exp_ev[i]); end
        end
        obs_ev.delete(); exp_ev.delete();
    endtask

    initial begin
        n_vec = 0; n_err = 0; overlap = 0;
        reset = 1'b1; word_tick_i = 1'b0; data_i = 8'h00; comma_i = 1'b0; error_i = 1'b0;
        test_reset();
        test_lock();
        test_good_frame();
        test_bad_checksum();
        test_error_payload();
        test_watchdog();
        test_restart_len();
        test_reset_midframe();
        test_random();
        n_vec++;
        if (overlap != 0) begin n_err++; $display("FAIL strobe_overlap: got %0d cycles required 0", overlap); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
